hex_display_scan: RTL and testbench

Time-multiplexed driver for a bank of common-anode 7-segment digits showing a multi-nibble hexadecimal value. It is the parametrised successor to the single-digit hex-to-segment decoder and sits between datapath logic (counters, ALU results, switch inputs) and the board's shared segment/anode pins. On top of plain decoding it adds:
- digit scanning with a programmable dwell time;
- tear-free value updates at frame boundaries;
- optional leading-zero blanking;
- a whole-display blink mode.

---
 rtl/hex_display_scan_pkg.sv | 35 +++
 rtl/hex_display_scan_if.sv | 29 ++
 rtl/hex_display_scan_decode.sv | 13 +
 rtl/hex_display_scan.sv | 118 +++++++++++
 tb/tb_hex_display_scan.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/hex_display_scan_pkg.sv
// Shared types and the hex-to-segment table for the hex display scanner.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package hex_disp_pkg;

  typedef logic [6:0] seg_t;

  // Active-low {g,f,e,d,c,b,a}; all ones turns every segment off.
  localparam seg_t SEG_BLANK = 7'h7F;

  // Standard 0-9 shapes, then A b C d E F so that b/d stay distinct from 8/0.
  function automatic seg_t hex_to_seg(input logic [3:0] hex);
    seg_t seg;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_display_scan_if.sv
// Bundle of value/control inputs and segment/anode outputs of the display scanner.
// Latency: none (wires only).
// Backpressure: none; load is a fire-and-forget strobe.
interface hex_display_scan_if #(
  parameter int DIGITS = 4
);
  import hex_disp_pkg::*;

  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic                  blank_lz;
  logic                  blink_en;
  seg_t                  seg;
  logic [DIGITS-1:0]     an;
  logic                  frame_start;

  // Datapath side: supplies the value and display modes, observes the pins.
  modport master (
    output load, value, blank_lz, blink_en,
    input  seg, an, frame_start
  );

  // Scanner side.
  modport slave (
    input  load, value, blank_lz, blink_en,
    output seg, an, frame_start
  );

endinterface

// File: rtl/hex_display_scan_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
// Latency: 0 cycles.
// Backpressure: none.
module hex7seg_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  assign seg = hex_to_seg(nib);

endmodule

// File: rtl/hex_display_scan.sv
// Time-multiplexed hex display driver with frame-aligned updates, zero blanking and blink.
// Latency: outputs registered 1 cycle after scan state; load visible within DIGITS*SCAN_DIV+1 cycles.
// Backpressure: none; the last load before a frame wrap wins.
module hex_display_scan
  import hex_disp_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic            clk,
  input  logic            rst,
  hex_display_scan_if.slave bus
);

  localparam int PCNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BCNT_W = $clog2(BLINK_FRAMES + 1);

  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pending_q, pending_d;
  logic [4*DIGITS-1:0] active_q, active_d;
  logic                phase_q, phase_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  seg_t                seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_start_q, frame_start_d;

  logic                tick, wrap;
  logic [3:0]          cur_nib;
  seg_t                cur_seg;
  logic                upper_zero, digit_blank, dark;

  // Scan, update and blink state: everything advances from the prescaler tick.
  always_comb begin
    tick      = (pcnt_q == PCNT_W'(SCAN_DIV - 1));
    wrap      = tick && (idx_q == IDX_W'(DIGITS - 1));
    pcnt_d    = tick ? '0 : pcnt_q + PCNT_W'(1);
    idx_d     = idx_q;
    pending_d = bus.load ? bus.value : pending_q;
    // Active only changes at the wrap so a frame never mixes old and new nibbles.
    active_d  = wrap ? pending_q : active_q;
    phase_d   = phase_q;
    bcnt_d    = bcnt_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end
    if (wrap) begin
      if (bcnt_q == BCNT_W'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BCNT_W'(1);
      end
    end
  end

  // Single shared decoder on the currently selected nibble.
  hex7seg_decode u_decode (
    .nib (cur_nib),
    .seg (cur_seg)
  );

  // Output pattern for the digit selected this cycle, registered next edge.
  always_comb begin
    cur_nib    = '0;
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib = active_q[4*i +: 4];
      end
      if ((IDX_W'(i) >= idx_q) && (active_q[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    // Digit 0 is never blanked so a zero value still shows one "0".
    digit_blank   = bus.blank_lz && (idx_q != '0) && upper_zero;
    dark          = bus.blink_en && !phase_q;
    seg_d         = cur_seg;
    an_d          = ~(DIGITS'(1) << idx_q);
    if (dark || digit_blank) begin
      seg_d = SEG_BLANK;
      an_d  = '1;
    end
    frame_start_d = (idx_q == '0) && (pcnt_q == '0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q        <= '0;
      idx_q         <= '0;
      pending_q     <= '0;
      active_q      <= '0;
      phase_q       <= 1'b1;
      bcnt_q        <= '0;
      seg_q         <= SEG_BLANK;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      pcnt_q        <= pcnt_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      active_q      <= active_d;
      phase_q       <= phase_d;
      bcnt_q        <= bcnt_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Randomized and scenario-driven bench for hex_display_scan against a timeline model.
// Latency: model predicts each cycle's outputs from elapsed cycles since reset.
// Backpressure: not applicable.
module tb_hex_display_scan;

  localparam int D     = 4;
  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = D * SD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hex_display_scan_if #(.DIGITS(D)) bus ();

  hex_display_scan #(
    .DIGITS       (D),
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          s        = 0;   // cycles elapsed since reset release (scan state index)
  logic [15:0] pend_m   = '0;
  logic [15:0] act_m    = '0;
  logic [6:0]  shape [16];
  logic        cur_blz  = 1'b0;
  logic        cur_ben  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (s=%0d, t=%0t)", tag, obs, exp, s, $time);
  endtask

  // One clock cycle: drive inputs, predict outputs, check, advance the model.
  task automatic step(input logic ld, input logic [15:0] v, input logic r);
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_fs;
    logic [3:0] nib;
    logic [15:0] upper;
    int         d, f;
    logic       lit_phase;
    @(negedge clk);
    rst          = r;
    bus.load     = ld;
    bus.value    = v;
    bus.blank_lz = cur_blz;
    bus.blink_en = cur_ben;
    if (r) begin
      e_seg = 7'h7F; e_an = 4'hF; e_fs = 1'b0;
    end else begin
      d         = (s / SD) % D;
      f         = s / FRAME;
      lit_phase = ((f / BF) % 2) == 0;
      e_fs      = (s % FRAME) == 0;
      nib       = act_m[4*d +: 4];
      upper     = act_m >> (4 * d);
      if ((cur_ben && !lit_phase) || (cur_blz && d > 0 && upper == 16'h0)) begin
        e_seg = 7'h7F; e_an = 4'hF;
      end else begin
        e_seg = shape[nib];
        e_an  = ~(4'b0001 << d);
      end
    end
    @(posedge clk);
    #1;
    check("seg", {25'h0, bus.seg}, {25'h0, e_seg});
    check("an", {28'h0, bus.an}, {28'h0, e_an});
    check("frame_start", {31'h0, bus.frame_start}, {31'h0, e_fs});
    if (r) begin
      s = 0; pend_m = '0; act_m = '0;
    end else begin
      if (((s + 1) % FRAME) == 0) act_m = pend_m;
      if (ld) pend_m = v;
      s++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    logic [15:0] mask;
    shape = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    bus.load = 1'b0; bus.value = '0; bus.blank_lz = 1'b0; bus.blink_en = 1'b0;

    // Reset held, then idle scanning of "0000".
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1);
    idle(40);

    // Mid-frame load becomes visible only after the frame wrap.
    idle(5);
    step(1'b1, 16'h12AF, 1'b0);
    idle(40);

    // Leading-zero blanking, including an all-zero value.
    cur_blz = 1'b1;
    step(1'b1, 16'h00B0, 1'b0);
    idle(40);
    step(1'b1, 16'h0000, 1'b0);
    idle(40);
    step(1'b1, 16'h0400, 1'b0);
    idle(40);
    cur_blz = 1'b0;

    // Whole-display blink.
    cur_ben = 1'b1;
    step(1'b1, 16'h8888, 1'b0);
    idle(140);
    cur_ben = 1'b0;

    // Two loads in one frame, then a load coinciding with the wrap tick.
    while ((s % FRAME) != 3) idle(1);
    step(1'b1, 16'h1111, 1'b0);
    idle(2);
    step(1'b1, 16'h2222, 1'b0);
    while (((s + 1) % FRAME) != 0) idle(1);
    step(1'b1, 16'h3333, 1'b0);
    idle(40);

    // Reset mid-frame discards a pending load.
    while ((s % FRAME) != 6) idle(1);
    step(1'b1, 16'hFFFF, 1'b0);
    idle(2);
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    idle(40);

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      case ($urandom_range(0, 3))
        0: mask = 16'hFFFF;
        1: mask = 16'h00FF;
        2: mask = 16'h000F;
        default: mask = 16'h0F00;
      endcase
      if ($urandom_range(0, 99) == 0) cur_blz = ~cur_blz;
      if ($urandom_range(0, 149) == 0) cur_ben = ~cur_ben;
      step($urandom_range(0, 7) == 0, 16'($urandom) & mask, $urandom_range(0, 399) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
